// File: rtl/ven_machine.sv
// Vending controller: takes a selection with an initial payment, collects top-up
// cash while short, then pulses the chosen product or refunds on cancel.
module ven_machine #(
    parameter int PRICE_NEWSPAPER = 5,
    parameter int PRICE_CADBURY   = 10,
    parameter int PRICE_JUICE     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] select_product,
    input  logic [4:0] money,
    input  logic [4:0] extra_cash,
    output logic       newspaper,
    output logic       cadbury_bar,
    output logic       juice,
    output logic [4:0] balance
);

    typedef enum logic [1:0] {IDLE, WAIT_CASH, DISPENSE, REFUND} state_t;

    state_t     state;
    logic [5:0] credit;
    logic [1:0] product;
    logic [5:0] init_price;
    logic [5:0] held_price;
    logic [5:0] topup;
    logic [5:0] paid;

    function automatic logic [5:0] price_of(input logic [1:0] code);
        case (code)
            2'b01:   price_of = 6'(PRICE_NEWSPAPER);
            2'b10:   price_of = 6'(PRICE_CADBURY);
            2'b11:   price_of = 6'(PRICE_JUICE);
            default: price_of = 6'd0;
        endcase
    endfunction

    // Credit never exceeds what the 5-bit balance output can report.
    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [4:0] b);
        logic [6:0] sum;
        sum = {1'b0, a} + {2'b00, b};
        sat_add = (sum > 7'd31) ? 6'd31 : sum[5:0];
    endfunction

    // Outputs ordered {juice, cadbury_bar, newspaper}.
    function automatic logic [2:0] pulse_of(input logic [1:0] code);
        case (code)
            2'b01:   pulse_of = 3'b001;
            2'b10:   pulse_of = 3'b010;
            2'b11:   pulse_of = 3'b100;
            default: pulse_of = 3'b000;
        endcase
    endfunction

    assign init_price = price_of(select_product);
    assign held_price = price_of(product);
    assign topup      = sat_add(credit, extra_cash);
    assign paid       = {1'b0, money};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                           <= IDLE;
            credit                          <= 6'd0;
            product                         <= 2'b00;
            {juice, cadbury_bar, newspaper} <= 3'b000;
            balance                         <= 5'd0;
        end else begin
            {juice, cadbury_bar, newspaper} <= 3'b000;
            balance                         <= 5'd0;
            case (state)
                IDLE: begin
                    if (select_product != 2'b00) begin
                        product <= select_product;
                        credit  <= paid;
                        if (paid >= init_price) begin
                            state                           <= DISPENSE;
                            {juice, cadbury_bar, newspaper} <= pulse_of(select_product);
                            balance                         <= 5'(paid - init_price);
                        end else begin
                            state <= WAIT_CASH;
                        end
                    end
                end
                WAIT_CASH: begin
                    if (select_product == 2'b00) begin
                        state   <= REFUND;
                        balance <= credit[4:0];
                    end else begin
                        credit <= topup;
                        if (topup >= held_price) begin
                            state                           <= DISPENSE;
                            {juice, cadbury_bar, newspaper} <= pulse_of(product);
                            balance                         <= 5'(topup - held_price);
                        end
                    end
                end
                DISPENSE, REFUND: begin
                    state  <= IDLE;
                    credit <= 6'd0;
                end
                default: begin
                    state  <= IDLE;
                    credit <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ven_machine.sv
// Scoreboard bench for ven_machine: a transaction-level model predicts each
// dispense/refund event and the cycle it appears; a monitor checks every cycle.
module tb_ven_machine;

    logic       clk;
    logic       reset;
    logic [1:0] select_product;
    logic [4:0] money;
    logic [4:0] extra_cash;
    logic       newspaper;
    logic       cadbury_bar;
    logic       juice;
    logic [4:0] balance;

    ven_machine dut (
        .clk            (clk),
        .reset          (reset),
        .select_product (select_product),
        .money          (money),
        .extra_cash     (extra_cash),
        .newspaper      (newspaper),
        .cadbury_bar    (cadbury_bar),
        .juice          (juice),
        .balance        (balance)
    );

    typedef struct {
        int         cyc;
        logic [2:0] prod;
        logic [4:0] bal;
    } exp_t;

    exp_t expq[$];
    int   topq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Prices are 5 units per step of product code.
    function automatic int price(input logic [1:0] p);
        return 5 * int'(p);
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] p);
        return 3'(3'b001 << (int'(p) - 1));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: anything not predicted must be silence.
    exp_t       mon_item;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp = 8'h00;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                mon_item = expq.pop_front();
                mon_exp  = {mon_item.prod, mon_item.bal};
            end
            check("outputs", {juice, cadbury_bar, newspaper, balance}, mon_exp);
        end
    end

    task automatic drive(input logic [1:0] s, input logic [4:0] m, input logic [4:0] x);
        @(posedge clk);
        #1;
        select_product = s;
        money          = m;
        extra_cash     = x;
    endtask

    // One purchase: initial payment, then top-ups from topq until paid; cancel if still short.
    task automatic run_txn(input logic [1:0] p, input logic [4:0] m, input bit noise);
        int         credit;
        int         pr;
        int         e;
        logic [4:0] x;
        logic [1:0] s;
        pr = price(p);
        drive(p, m, 5'($urandom_range(0, 31)));
        e = cyc + 1;
        credit = int'(m);
        while (credit < pr && topq.size() > 0) begin
            x = 5'(topq.pop_front());
            s = (noise && $urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : p;
            drive(s, noise ? 5'($urandom_range(0, 31)) : 5'd0, x);
            e = cyc + 1;
            credit = (credit + int'(x) > 31) ? 31 : credit + int'(x);
        end
        if (credit >= pr) begin
            expq.push_back('{e, onehot(p), 5'(credit - pr)});
        end else begin
            drive(2'b00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            e = cyc + 1;
            expq.push_back('{e, 3'b000, 5'(credit)});
        end
        topq.delete();
        drive(2'b00, 5'd0, 5'd0);
    endtask

    initial begin
        int e;
        reset          = 1'b0;
        select_product = 2'b00;
        money          = 5'd0;
        extra_cash     = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {juice, cadbury_bar, newspaper, balance}, 8'h00);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        run_txn(2'b01, 5'd5, 1'b0);
        run_txn(2'b10, 5'd20, 1'b0);
        topq = '{5};
        run_txn(2'b10, 5'd5, 1'b0);
        topq = '{5, 10};
        run_txn(2'b11, 5'd5, 1'b0);
        run_txn(2'b11, 5'd10, 1'b0);
        topq = '{31};
        run_txn(2'b11, 5'd14, 1'b0);
        topq = '{15};
        run_txn(2'b11, 5'd0, 1'b0);
        topq = '{1};
        run_txn(2'b10, 5'd9, 1'b0);
        run_txn(2'b01, 5'd31, 1'b0);

        // Held selection repeats a purchase every other cycle.
        drive(2'b01, 5'd7, 5'd0);
        e = cyc + 1;
        for (int k = 0; k < 3; k++) expq.push_back('{e + 2 * k, 3'b001, 5'd2});
        repeat (5) @(posedge clk);
        #1;
        select_product = 2'b00;
        money          = 5'd0;
        repeat (2) @(posedge clk);

        // Reset while waiting for cash: credit is discarded.
        drive(2'b11, 5'd5, 5'd0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("reset_wait_cash", {juice, cadbury_bar, newspaper, balance}, 8'h00);
        @(posedge clk);
        #1;
        select_product = 2'b00;
        extra_cash     = 5'd10;
        reset          = 1'b1;
        mon_en         = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        extra_cash = 5'd0;

        // Reset during the dispense cycle clears the pulse at once.
        drive(2'b01, 5'd9, 5'd0);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("dispense_before_reset", {juice, cadbury_bar, newspaper, balance}, {3'b001, 5'd4});
        reset = 1'b0;
        #1;
        check("reset_in_dispense", {juice, cadbury_bar, newspaper, balance}, 8'h00);
        select_product = 2'b00;
        money          = 5'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++)
                topq.push_back(($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 12));
            run_txn(2'($urandom_range(1, 3)), 5'($urandom_range(0, 31)), 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 8'(expq.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ven_machine.md
Name: ven_machine

Overview:
- Single-clock vending controller. Sells three products: newspaper, cadbury_bar and juice.
- Accepts an initial payment with the product selection, then accepts top-up cash if the payment is short.
- Dispenses the product as a one-cycle pulse and reports change or refund on balance.
- Leaf block between the coin/selection front panel and the dispenser actuators.

Parameters:
- PRICE_NEWSPAPER, 5, price of product code 2'b01
- PRICE_CADBURY, 10, price of product code 2'b10
- PRICE_JUICE, 15, price of product code 2'b11

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (0 = reset)
- select_product  input  2  00 none/cancel, 01 newspaper, 10 cadbury_bar, 11 juice
- money  input  5  initial payment, sampled only in IDLE when select_product != 00
- extra_cash  input  5  top-up deposit, sampled only in WAIT_CASH; each nonzero cycle is one deposit
- newspaper  output  1  one-cycle dispense pulse
- cadbury_bar  output  1  one-cycle dispense pulse
- juice  output  1  one-cycle dispense pulse
- balance  output  5  change or refund amount; valid in the dispense/refund cycle, 0 otherwise

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces the following, and holds while reset is low:
  - state = IDLE
  - credit = 0, latched product = 00
  - newspaper = cadbury_bar = juice = 0, balance = 0
- Internal state: 6-bit credit register; 2-bit latched product code.
- States: IDLE, WAIT_CASH, DISPENSE, REFUND.
- IDLE:
  - select_product == 00: stay in IDLE.
  - Otherwise latch the product and set credit = money.
  - If money >= price: go to DISPENSE, else go to WAIT_CASH.
  - money == 0 with a selection is legal and goes to WAIT_CASH with credit 0.
- WAIT_CASH:
  - money is ignored.
  - select_product == 00 cancels: go to REFUND.
  - Otherwise credit <= min(credit + extra_cash, 31).
  - If the updated credit >= price, go to DISPENSE next edge; else stay.
  - A changed nonzero select_product in WAIT_CASH is ignored; the latched product stands.
- DISPENSE (exactly one cycle):
  - The latched product's output = 1; the other two = 0.
  - balance = credit − price.
  - Next state IDLE; credit cleared.
- REFUND (one cycle):
  - All product outputs 0; balance = credit.
  - Next state IDLE; credit cleared.
- IDLE and WAIT_CASH: all product outputs 0, balance 0.
- Latency:
  - Sufficient initial payment: dispense pulse is registered 1 cycle after the IDLE edge that samples the selection. It is visible in the cycle following the sampling edge.
  - Top-up completing the price: pulse follows 1 cycle after that deposit edge.
- Back-to-back: after DISPENSE returns to IDLE, a still-asserted nonzero select_product starts a new transaction on that IDLE edge. Repeated purchases with held inputs are intended.
- Arithmetic:
  - 6-bit internal sums; credit saturates at 31.
  - credit − price never underflows (DISPENSE is only entered with credit >= price).
- Reset mid-transaction discards credit with no refund and no pulse.
- At most one product output is high in any cycle.

Test Plan:
- Reset low then release, inputs idle → all outputs 0, balance 0, stays IDLE.
- select=01, money=5 → newspaper pulses 1 cycle, balance=0; select=10, money=20 → cadbury_bar pulse, balance=10.
- select=10, money=5 → WAIT_CASH, no pulse. Next cycle extra_cash=5 for one cycle → cadbury_bar pulse, balance=0.
- select=11, money=5; then extra_cash=5, then extra_cash=10 (one cycle each) → credit 10, then 20 → juice pulse, balance=5.
- select=11, money=10 → WAIT_CASH; select=00 → REFUND cycle, balance=10, no product pulse, back to IDLE.
- select=11, money=5, then reset asserted in WAIT_CASH → immediate outputs 0. After release, extra_cash=10 produces no pulse (IDLE).
